mic_channel_scheduler: RTL and testbench

Selects which of NCH microphone sample streams feeds the single shared loudness-meter pipeline (abs → IIR → log → LED encoder). It holds one output register, forwards the active channel with valid/ready backpressure, and discards samples from inactive channels so no microphone ever stalls. Channel selection is manual (`sel_ch`) or automatic, rotating every DWELL accepted samples. Every channel change is drained cleanly and flagged to downstream logic.

---
 rtl/loudness_meter_pkg.sv | 4 +
 rtl/mic_channel_scheduler.sv | 121 ++++++++++++
 tb/tb_mic_channel_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loudness_meter_pkg.sv
// Shared types for the loudness-meter pipeline.
package loudness_meter_pkg;
  typedef logic signed [15:0] data_t;
endpackage

// File: rtl/mic_channel_scheduler.sv
// Picks one of NCH microphone streams for the shared loudness pipeline, dropping
// samples from inactive channels and draining the output register on every switch.
module mic_channel_scheduler
  import loudness_meter_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DWELL = 4800,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              arstn,
  input  data_t             in_data [NCH],
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              auto_scan,
  input  logic [CW-1:0]     sel_ch,
  output data_t             out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     cur_ch,
  output logic              switch_pulse
);

  localparam int              CNTW     = $clog2(DWELL + 1);
  localparam logic [CNTW-1:0] DWELL_M1 = CNTW'(DWELL - 1);
  localparam logic [CW-1:0]   LAST_CH  = CW'(NCH - 1);
  localparam logic [CW:0]     NCH_W    = (CW + 1)'(NCH);

  // state | meaning
  // FWD   | forwarding cur_ch into the output register
  // DRAIN | waiting for the last old-channel sample to leave before switching
  typedef enum logic {FWD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d, target_q, target_d, next_ch, req_ch;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d, pulse_q, pulse_d;
  data_t           out_data_q, out_data_d, cur_data;
  logic            room, cur_valid, take, wrap, req;

  assign room      = out_ready || !out_valid_q;
  assign cur_valid = in_valid[cur_ch_q];
  assign cur_data  = in_data[cur_ch_q];
  assign take      = (state_q == FWD) && cur_valid && room;
  assign wrap      = take && (cnt_q == DWELL_M1);
  assign next_ch   = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;

  // Inactive channels are always drained; the active one only blocks in FWD.
  always_comb begin
    in_ready = '1;
    if (state_q == FWD) in_ready[cur_ch_q] = room;
  end

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pulse_d     = 1'b0;
    req         = 1'b0;
    req_ch      = cur_ch_q;
    case (state_q)
      FWD: begin
        if (room) out_valid_d = cur_valid;
        if (take) begin
          out_data_d = cur_data;
          cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        end
        if (auto_scan && wrap) begin
          req    = 1'b1;
          req_ch = next_ch;
        end else if (!auto_scan && (sel_ch != cur_ch_q) && ({1'b0, sel_ch} < NCH_W)) begin
          req    = 1'b1;
          req_ch = sel_ch;
        end
        if (req && (req_ch != cur_ch_q)) begin
          target_d = req_ch;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (room) begin
          out_valid_d = 1'b0;
          cur_ch_d    = target_q;
          cnt_d       = '0;
          pulse_d     = 1'b1;
          state_d     = FWD;
        end
      end
      default: state_d = FWD;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= FWD;
      cur_ch_q    <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pulse_q     <= pulse_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign cur_ch       = cur_ch_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_mic_channel_scheduler.sv
// Bench for mic_channel_scheduler: directed scenarios plus a randomized run
// against a sample-level reference model.
module tb_mic_channel_scheduler;
  import loudness_meter_pkg::*;

  localparam int NCH = 4, DWELL = 3, CW = 2;
  localparam int BNCH = 5, BCW = 3;

  logic clk = 1'b0;
  logic arstn;
  data_t in_data [NCH];
  logic [NCH-1:0] in_valid, in_ready;
  logic auto_scan, out_valid, out_ready, switch_pulse;
  logic [CW-1:0] sel_ch, cur_ch;
  data_t out_data;

  data_t b_in_data [BNCH];
  logic [BNCH-1:0] b_in_valid, b_in_ready;
  logic b_auto_scan, b_out_valid, b_out_ready, b_switch_pulse;
  logic [BCW-1:0] b_sel_ch, b_cur_ch;
  data_t b_out_data;

  int n_checks = 0, n_fail = 0;

  // reference model state
  int m_ch, m_cnt, m_target;
  bit m_valid, m_drain, m_pulse;
  data_t m_data;

  mic_channel_scheduler #(.NCH(NCH), .DWELL(DWELL)) dut (
    .clk(clk), .arstn(arstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .auto_scan(auto_scan), .sel_ch(sel_ch), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .cur_ch(cur_ch), .switch_pulse(switch_pulse));

  mic_channel_scheduler #(.NCH(BNCH), .DWELL(DWELL)) dut_b (
    .clk(clk), .arstn(arstn), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .auto_scan(b_auto_scan), .sel_ch(b_sel_ch), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .cur_ch(b_cur_ch), .switch_pulse(b_switch_pulse));

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ch = 0; m_cnt = 0; m_target = 0;
    m_valid = 1'b0; m_drain = 1'b0; m_pulse = 1'b0; m_data = '0;
  endfunction

  // One clock of behaviour: which sample is taken, whether a dwell completes,
  // and whether the channel change finishes this cycle.
  function automatic void model_step();
    bit room, take;
    int req;
    room = out_ready || !m_valid;
    req = -1;
    if (!m_drain) begin
      take = in_valid[m_ch] && room;
      if (room) m_valid = in_valid[m_ch];
      if (take) begin
        m_data = in_data[m_ch];
        m_cnt++;
        if (m_cnt == DWELL) begin
          m_cnt = 0;
          if (auto_scan) req = (m_ch + 1) % NCH;
        end
      end
      if (!auto_scan && int'(sel_ch) != m_ch && int'(sel_ch) < NCH) req = int'(sel_ch);
      m_pulse = 1'b0;
      if (req >= 0 && req != m_ch) begin
        m_drain = 1'b1;
        m_target = req;
      end
    end else begin
      m_pulse = room;
      if (room) begin
        m_valid = 1'b0; m_ch = m_target; m_cnt = 0; m_drain = 1'b0;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] exp_ready();
    logic [NCH-1:0] r;
    r = '1;
    if (!m_drain) r[m_ch] = out_ready || !m_valid;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!arstn) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic drive_seq(input int seq);
    for (int c = 0; c < NCH; c++) in_data[c] = 16'(c * 4096 + seq);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    in_valid = '0; out_ready = 1'b1; auto_scan = 1'b0; sel_ch = '0;
    b_in_valid = '0; b_out_ready = 1'b1; b_auto_scan = 1'b0; b_sel_ch = '0;
    model_reset();
    tick(); tick();
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'($urandom); out_ready = 1'($urandom); auto_scan = 1'($urandom);
      sel_ch = 2'($urandom);
      for (int c = 0; c < NCH; c++) in_data[c] = 16'($urandom);
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || cur_ch !== 2'd0 || switch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%b ch=%0d pulse=%b, expected 0/0/0", out_valid, cur_ch, switch_pulse);
      end
      #1;
      n_checks++;
      if (in_ready !== 4'b1111) begin
        n_fail++;
        $display("FAIL reset_in_ready: got %b expected 1111", in_ready);
      end
      @(negedge clk);
    end
    arstn = 1'b1;
    in_valid = 4'b0001; in_data[0] = 16'h1234; out_ready = 1'b1; auto_scan = 1'b0; sel_ch = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL reset_first_sample: got valid=%b data=%h expected 1/1234", out_valid, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_manual_select();
    int pulses = 0, pulse_cyc = -1, pulse_ch = -1, old_after = 0, n300 = 0, other_after = 0;
    do_reset();
    in_data[0] = 16'd100; in_data[1] = 16'd200; in_data[2] = 16'd300; in_data[3] = 16'd400;
    in_valid = '1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 10) sel_ch = 2'd2;
      tick();
      if (switch_pulse) begin
        pulses++; pulse_cyc = cyc; pulse_ch = int'(cur_ch);
      end else if (pulses > 0 && out_valid) begin
        if (out_data == 16'd100) old_after++;
        if (out_data == 16'd300) n300++; else other_after++;
      end
    end
    n_checks++;
    if (pulses != 1 || pulse_cyc != 11) begin
      n_fail++;
      $display("FAIL manual_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 11", pulses, pulse_cyc);
    end
    n_checks++;
    if (pulse_ch != 2) begin
      n_fail++;
      $display("FAIL manual_cur_ch: got %0d expected 2", pulse_ch);
    end
    n_checks++;
    if (old_after != 0 || other_after != 0 || n300 != 18) begin
      n_fail++;
      $display("FAIL manual_stream: got old=%0d other=%0d n300=%0d expected 0/0/18", old_after, other_after, n300);
    end
  endtask

  task automatic test_auto_scan();
    int k = 0, pulses = 0, seq = 0, cyc = 0;
    do_reset();
    auto_scan = 1'b1; in_valid = '1;
    while (k < 15 && cyc < 100) begin
      drive_seq(seq); seq++; cyc++;
      tick();
      if (switch_pulse) begin
        pulses++;
        n_checks++;
        if (int'(cur_ch) != pulses % NCH) begin
          n_fail++;
          $display("FAIL auto_pulse_ch: got %0d expected %0d", cur_ch, pulses % NCH);
        end
      end
      if (out_valid) begin
        n_checks++;
        if (int'(out_data[15:12]) != (k / DWELL) % NCH) begin
          n_fail++;
          $display("FAIL auto_order: output %0d from ch %0d expected ch %0d", k, out_data[15:12], (k / DWELL) % NCH);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 15 || pulses != 4) begin
      n_fail++;
      $display("FAIL auto_totals: got %0d outputs %0d pulses, expected 15 outputs 4 pulses", k, pulses);
    end
  endtask

  task automatic test_backpressure();
    data_t held, exp1;
    do_reset();
    in_valid = '1;
    for (int s = 1; s <= 4; s++) begin
      drive_seq(s);
      tick();
    end
    held = 16'd4;
    sel_ch = 2'd1; out_ready = 1'b0; drive_seq(5);
    #1;
    n_checks++;
    if (in_ready !== 4'b1110) begin
      n_fail++;
      $display("FAIL bp_stall_ready: got %b expected 1110", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      drive_seq(6 + i);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held || cur_ch !== 2'd0 || switch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b data=%0d ch=%0d pulse=%b expected 1/%0d/0/0", out_valid, out_data, cur_ch, switch_pulse, held);
      end
      #1;
      n_checks++;
      if (in_ready !== 4'b1111) begin
        n_fail++;
        $display("FAIL bp_drain_ready: got %b expected 1111", in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (cur_ch !== 2'd1 || switch_pulse !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_switch: got ch=%0d pulse=%b valid=%b expected 1/1/0", cur_ch, switch_pulse, out_valid);
    end
    drive_seq(20);
    exp1 = 16'(4096 + 20);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp1 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_new_ch: got valid=%b data=%0d pulse=%b expected 1/%0d/0", out_valid, out_data, switch_pulse, exp1);
    end
  endtask

  task automatic test_invalid_noop();
    data_t exp_d;
    do_reset();
    in_valid = '1; b_in_valid = '1;
    for (int k = 0; k < 12; k++) begin
      sel_ch = '0;
      b_sel_ch = (k < 6) ? 3'(5 + $urandom_range(0, 2)) : 3'd0;
      exp_d = 16'(k + 7);
      for (int c = 0; c < BNCH; c++) b_in_data[c] = 16'(c * 4096 + k + 7);
      drive_seq(k + 7);
      tick();
      n_checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_d || b_cur_ch !== 3'd0 || b_switch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL noop_invalid_sel: got valid=%b data=%0d ch=%0d pulse=%b expected 1/%0d/0/0", b_out_valid, b_out_data, b_cur_ch, b_switch_pulse, exp_d);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || cur_ch !== 2'd0 || switch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL noop_same_sel: got valid=%b data=%0d ch=%0d pulse=%b expected 1/%0d/0/0", out_valid, out_data, cur_ch, switch_pulse, exp_d);
      end
    end
    b_in_valid = '0;
  endtask

  task automatic test_reset_mid_drain();
    int n0 = 0, cyc = 0, seq = 50;
    bit seen_pulse = 1'b0;
    do_reset();
    in_valid = '1; drive_seq(1);
    sel_ch = 2'd2;
    tick(); tick(); tick();
    sel_ch = 2'd3; out_ready = 1'b0;
    tick();
    n_checks++;
    if (cur_ch !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_drain_pre: got ch=%0d valid=%b expected 2/1", cur_ch, out_valid);
    end
    #2;
    arstn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || cur_ch !== 2'd0 || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drain_async: got valid=%b ch=%0d pulse=%b expected 0/0/0", out_valid, cur_ch, switch_pulse);
    end
    @(negedge clk);
    tick();
    arstn = 1'b1; auto_scan = 1'b1; out_ready = 1'b1; sel_ch = '0;
    while (!seen_pulse && cyc < 30) begin
      drive_seq(seq); seq++; cyc++;
      tick();
      if (switch_pulse) seen_pulse = 1'b1;
      else if (out_valid && out_data[15:12] == 4'd0) n0++;
    end
    n_checks++;
    if (!seen_pulse || n0 != DWELL) begin
      n_fail++;
      $display("FAIL rst_drain_restart: got %0d ch0 outputs pulse=%b, expected %0d and 1", n0, seen_pulse, DWELL);
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] er;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      in_valid = 4'($urandom);
      for (int c = 0; c < NCH; c++) in_data[c] = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) auto_scan = ~auto_scan;
      if ($urandom_range(0, 7) == 0) sel_ch = 2'($urandom);
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er) begin
        n_fail++;
        $display("FAIL rand_in_ready: cycle %0d got %b expected %b", k, in_ready, er);
      end
      tick();
      n_checks++;
      if (out_valid !== m_valid || cur_ch !== 2'(m_ch) || switch_pulse !== m_pulse) begin
        n_fail++;
        $display("FAIL rand_ctrl: cycle %0d got valid=%b ch=%0d pulse=%b expected %b/%0d/%b", k, out_valid, cur_ch, switch_pulse, m_valid, m_ch, m_pulse);
      end
      if (m_valid) begin
        n_checks++;
        if (out_data !== m_data) begin
          n_fail++;
          $display("FAIL rand_data: cycle %0d got %h expected %h", k, out_data, m_data);
        end
      end
    end
  endtask

  initial begin
    arstn = 1'b0;
    in_valid = '0; out_ready = 1'b1; auto_scan = 1'b0; sel_ch = '0;
    b_in_valid = '0; b_out_ready = 1'b1; b_auto_scan = 1'b0; b_sel_ch = '0;
    for (int c = 0; c < NCH; c++) in_data[c] = '0;
    for (int c = 0; c < BNCH; c++) b_in_data[c] = '0;
    model_reset();
    test_reset();
    test_manual_select();
    test_auto_scan();
    test_backpressure();
    test_invalid_noop();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
